// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the CPU state-machine FIFO controller:
// FIFO geometry, the fill watermark and the request-FSM state encoding.
package fifo_ctrl_pkg;

    localparam int CNT_W = 4;
    localparam int PTR_W = 3;

    // The FIFO holds 8 longwords; DMA reads start once 4 are buffered.
    localparam logic [CNT_W-1:0] FIFO_DEPTH = 4'd8;
    localparam logic [CNT_W-1:0] WATERMARK  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_FILL     = 3'd2,
        ST_FLUSHING = 3'd3,
        ST_DONE     = 3'd4
    } req_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// 3-bit wrapping FIFO pointer with synchronous clear and count enable.
module fifo_ptr
    import fifo_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    // Advance on each enable strobe; 7 rolls over to 0 naturally.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples values from before the edge, independent of block order.
        if (rst || clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO occupancy tracker and CPU-SM request generator for the SCSI DMA path.
// Tracks longwords held, read/write pointers, a sticky error flag, and raises
// the active-low read/write requests that pace the CPU state machine.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR_FIFO,
    input  logic             DIR,
    input  logic             FLUSH,
    input  logic             INCFIFO,
    input  logic             DECFIFO,
    input  logic             INCNI,
    input  logic             INCNO,
    output logic [CNT_W-1:0] FIFO_CNT,
    output logic [PTR_W-1:0] WRPTR,
    output logic [PTR_W-1:0] RDPTR,
    output logic             FIFOFULL,
    output logic             FIFOEMPTY,
    output logic             RDFIFO_,
    output logic             RIFIFO_,
    output logic             FLUSH_DONE,
    output logic             FIFO_ERR
);

    logic [CNT_W-1:0] cnt;
    logic             err;
    req_state_t       state;
    logic             rd_req_n;
    logic             wr_req_n;
    logic             flush_done;
    // Cleared when a flush completes; re-armed only once FLUSH is seen low,
    // so a FLUSH level held high cannot produce a second completion.
    logic             flush_armed;

    logic inc_only;
    logic dec_only;
    logic drain_empty;
    logic fill_full;

    assign inc_only = INCFIFO & ~DECFIFO;
    assign dec_only = DECFIFO & ~INCFIFO;

    // Emptiness/fullness as it will stand after this edge's strobe.
    assign drain_empty = (cnt == '0) || ((cnt == 4'd1) && dec_only);
    assign fill_full   = (cnt == FIFO_DEPTH) ||
                         ((cnt == FIFO_DEPTH - 4'd1) && inc_only);

    fifo_ptr u_wr_ptr (
        .clk (CLK),
        .rst (RST),
        .clr (CLR_FIFO),
        .en  (INCNI),
        .ptr (WRPTR)
    );

    fifo_ptr u_rd_ptr (
        .clk (CLK),
        .rst (RST),
        .clr (CLR_FIFO),
        .en  (INCNO),
        .ptr (RDPTR)
    );

    // Occupancy count with saturation; over/underflow attempts latch an error.
    always_ff @(posedge CLK) begin
        if (RST || CLR_FIFO) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (inc_only) begin
            if (cnt == FIFO_DEPTH) err <= 1'b1;
            else                   cnt <= cnt + 4'd1;
        end else if (dec_only) begin
            if (cnt == '0) err <= 1'b1;
            else           cnt <= cnt - 4'd1;
        end
    end

    // Request FSM; request and done outputs are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            rd_req_n    <= 1'b1;
            wr_req_n    <= 1'b1;
            flush_done  <= 1'b0;
            flush_armed <= 1'b1;
        end else begin
            if (!FLUSH) flush_armed <= 1'b1;

            rd_req_n   <= 1'b1;
            wr_req_n   <= 1'b1;
            flush_done <= 1'b0;

            if (CLR_FIFO) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (DIR && FLUSH && flush_armed && (cnt != '0)) begin
                            state    <= ST_FLUSHING;
                            rd_req_n <= 1'b0;
                        end else if (DIR && (cnt >= WATERMARK)) begin
                            state    <= ST_DRAIN;
                            rd_req_n <= 1'b0;
                        end else if (DIR && FLUSH && flush_armed && (cnt == '0)) begin
                            state       <= ST_DONE;
                            flush_done  <= 1'b1;
                            flush_armed <= 1'b0;
                        end else if (!DIR && (cnt <= WATERMARK)) begin
                            state    <= ST_FILL;
                            wr_req_n <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (!DIR || drain_empty) state    <= ST_IDLE;
                        else                     rd_req_n <= 1'b0;
                    end
                    ST_FILL: begin
                        if (DIR || fill_full) state    <= ST_IDLE;
                        else                  wr_req_n <= 1'b0;
                    end
                    ST_FLUSHING: begin
                        if (!DIR) begin
                            state <= ST_IDLE;
                        end else if (drain_empty) begin
                            state       <= ST_DONE;
                            flush_done  <= 1'b1;
                            flush_armed <= 1'b0;
                        end else begin
                            rd_req_n <= 1'b0;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign FIFO_CNT   = cnt;
    assign FIFOFULL   = (cnt == FIFO_DEPTH);
    assign FIFOEMPTY  = (cnt == '0);
    assign RDFIFO_    = rd_req_n;
    assign RIFIFO_    = wr_req_n;
    assign FLUSH_DONE = flush_done;
    assign FIFO_ERR   = err;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: directed scenarios plus random traffic,
// checked against a behavioural model of the controller.
module tb_fifo_ctrl;

    logic       CLK;
    logic       RST, CLR_FIFO, DIR, FLUSH;
    logic       INCFIFO, DECFIFO, INCNI, INCNO;
    logic [3:0] FIFO_CNT;
    logic [2:0] WRPTR, RDPTR;
    logic       FIFOFULL, FIFOEMPTY, RDFIFO_, RIFIFO_, FLUSH_DONE, FIFO_ERR;

    fifo_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .CLR_FIFO   (CLR_FIFO),
        .DIR        (DIR),
        .FLUSH      (FLUSH),
        .INCFIFO    (INCFIFO),
        .DECFIFO    (DECFIFO),
        .INCNI      (INCNI),
        .INCNO      (INCNO),
        .FIFO_CNT   (FIFO_CNT),
        .WRPTR      (WRPTR),
        .RDPTR      (RDPTR),
        .FIFOFULL   (FIFOFULL),
        .FIFOEMPTY  (FIFOEMPTY),
        .RDFIFO_    (RDFIFO_),
        .RIFIFO_    (RIFIFO_),
        .FLUSH_DONE (FLUSH_DONE),
        .FIFO_ERR   (FIFO_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit rst, clr, dir, flush, inc, dec, incni, inco;
    } stim_t;

    typedef struct {
        int cnt, wr, rd;
        bit full, empty, rd_n, wr_n, done, err;
    } exp_t;

    // Model's view of what the controller is doing with the CPU SM.
    typedef enum {M_IDLE, M_READING, M_WRITING, M_FLUSHING, M_FLUSHED} mode_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    exp_t  sb[$];

    int    m_cnt, m_wr, m_rd;
    bit    m_err, m_armed;
    mode_t m_mode;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge's worth of stimulus to the reference model.
    task automatic model_edge(input stim_t s);
        int  c;
        bit  inc1, dec1, emptying, filling;
        c    = m_cnt;
        inc1 = s.inc && !s.dec;
        dec1 = s.dec && !s.inc;
        emptying = (c == 0) || (c == 1 && dec1);
        filling  = (c == 8) || (c == 7 && inc1);
        if (s.rst) begin
            m_cnt = 0; m_wr = 0; m_rd = 0; m_err = 0;
            m_mode = M_IDLE; m_armed = 1;
            return;
        end
        if (s.clr) begin
            m_cnt = 0; m_wr = 0; m_rd = 0; m_err = 0;
            m_mode = M_IDLE;
            if (!s.flush) m_armed = 1;
            return;
        end
        if (inc1) begin
            if (c == 8) m_err = 1; else m_cnt = c + 1;
        end else if (dec1) begin
            if (c == 0) m_err = 1; else m_cnt = c - 1;
        end
        m_wr = (m_wr + int'(s.incni)) % 8;
        m_rd = (m_rd + int'(s.inco)) % 8;
        if (!s.flush) m_armed = 1;
        case (m_mode)
            M_IDLE:
                if (s.dir && s.flush && m_armed && c > 0) m_mode = M_FLUSHING;
                else if (s.dir && c >= 4)                 m_mode = M_READING;
                else if (s.dir && s.flush && m_armed)     m_mode = M_FLUSHED;
                else if (!s.dir && c <= 4)                m_mode = M_WRITING;
            M_READING:  if (!s.dir || emptying) m_mode = M_IDLE;
            M_WRITING:  if (s.dir || filling)   m_mode = M_IDLE;
            M_FLUSHING:
                if (!s.dir)        m_mode = M_IDLE;
                else if (emptying) m_mode = M_FLUSHED;
            M_FLUSHED:  m_mode = M_IDLE;
            default:    m_mode = M_IDLE;
        endcase
        if (m_mode == M_FLUSHED) m_armed = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.cnt   = m_cnt;
        e.wr    = m_wr;
        e.rd    = m_rd;
        e.full  = (m_cnt == 8);
        e.empty = (m_cnt == 0);
        e.rd_n  = !(m_mode == M_READING || m_mode == M_FLUSHING);
        e.wr_n  = !(m_mode == M_WRITING);
        e.done  = (m_mode == M_FLUSHED);
        e.err   = m_err;
        return e;
    endfunction

    function automatic stim_t st(bit rst, bit clr, bit dir, bit flush,
                                 bit inc, bit dec, bit incni, bit inco);
        stim_t s;
        s.rst = rst; s.clr = clr; s.dir = dir; s.flush = flush;
        s.inc = inc; s.dec = dec; s.incni = incni; s.inco = inco;
        return s;
    endfunction

    task automatic step(input stim_t s);
        @(negedge CLK);
        RST = s.rst; CLR_FIFO = s.clr; DIR = s.dir; FLUSH = s.flush;
        INCFIFO = s.inc; DECFIFO = s.dec; INCNI = s.incni; INCNO = s.inco;
        model_edge(s);
        sb.push_back(model_out());
    endtask

    task automatic settle();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every edge the DUT presents a fresh output set; compare it
    // against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("cnt",        FIFO_CNT,   8'(e.cnt));
                check("wrptr",      WRPTR,      8'(e.wr));
                check("rdptr",      RDPTR,      8'(e.rd));
                check("full",       FIFOFULL,   8'(e.full));
                check("empty",      FIFOEMPTY,  8'(e.empty));
                check("rdfifo_n",   RDFIFO_,    8'(e.rd_n));
                check("rififo_n",   RIFIFO_,    8'(e.wr_n));
                check("flush_done", FLUSH_DONE, 8'(e.done));
                check("fifo_err",   FIFO_ERR,   8'(e.err));
                check("req_excl",   8'(!RDFIFO_ && !RIFIFO_), 8'd0);
            end
        end
    end

    initial begin
        bit d, f;
        int pulses;
        RST = 1'b1; CLR_FIFO = 1'b0; DIR = 1'b1; FLUSH = 1'b0;
        INCFIFO = 1'b0; DECFIFO = 1'b0; INCNI = 1'b0; INCNO = 1'b0;
        m_cnt = 0; m_wr = 0; m_rd = 0; m_err = 0; m_mode = M_IDLE; m_armed = 1;

        // Reset, five fills with DIR=1 reach the watermark, then drain.
        step(st(1, 0, 1, 0, 0, 0, 0, 0));
        settle();
        check("rst_cnt",   FIFO_CNT,  8'd0);
        check("rst_empty", FIFOEMPTY, 8'd1);
        check("rst_rd_n",  RDFIFO_,   8'd1);
        check("rst_wr_n",  RIFIFO_,   8'd1);
        repeat (5) step(st(0, 0, 1, 0, 1, 0, 0, 0));
        settle();
        check("drain_cnt5", FIFO_CNT, 8'd5);
        check("drain_rd_n", RDFIFO_,  8'd0);
        repeat (5) step(st(0, 0, 1, 0, 0, 1, 0, 0));
        settle();
        check("drain_cnt0",  FIFO_CNT, 8'd0);
        check("drain_rd_n1", RDFIFO_,  8'd1);

        // Overflow at 8 is sticky until CLR_FIFO.
        step(st(0, 1, 1, 0, 0, 0, 0, 0));
        repeat (9) step(st(0, 0, 1, 0, 1, 0, 0, 0));
        settle();
        check("ovf_cnt", FIFO_CNT, 8'd8);
        check("ovf_err", FIFO_ERR, 8'd1);
        step(st(0, 1, 1, 0, 0, 0, 0, 0));
        settle();
        check("clr_cnt", FIFO_CNT, 8'd0);
        check("clr_err", FIFO_ERR, 8'd0);

        // Simultaneous strobes hold; write pointer wraps after 8.
        repeat (3) step(st(0, 0, 1, 0, 1, 0, 0, 0));
        step(st(0, 0, 1, 0, 1, 1, 0, 0));
        settle();
        check("both_hold", FIFO_CNT, 8'd3);
        repeat (9) step(st(0, 0, 1, 0, 0, 0, 1, 0));
        settle();
        check("wrptr_wrap", WRPTR, 8'd1);

        // Flush a partial FIFO of 2; exactly one FLUSH_DONE while FLUSH held.
        step(st(0, 1, 1, 0, 0, 0, 0, 0));
        repeat (2) step(st(0, 0, 1, 0, 1, 0, 0, 0));
        step(st(0, 0, 1, 1, 0, 0, 0, 0));
        settle();
        check("flush_rd_n", RDFIFO_, 8'd0);
        step(st(0, 0, 1, 1, 0, 1, 0, 0));
        step(st(0, 0, 1, 1, 0, 1, 0, 0));
        settle();
        check("flush_done", FLUSH_DONE, 8'd1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(st(0, 0, 1, 1, 0, 0, 0, 0));
            settle();
            pulses += int'(FLUSH_DONE);
        end
        check("flush_no_repeat", 8'(pulses), 8'd0);
        step(st(0, 0, 1, 0, 0, 0, 0, 0));

        // Fill from empty to full with DIR=0, then flip DIR mid-fill.
        step(st(0, 1, 0, 0, 0, 0, 0, 0));
        step(st(0, 0, 0, 0, 0, 0, 0, 0));
        settle();
        check("fill_wr_n", RIFIFO_, 8'd0);
        repeat (8) step(st(0, 0, 0, 0, 1, 0, 0, 0));
        settle();
        check("fill_wr_n1", RIFIFO_,  8'd1);
        check("fill_full",  FIFOFULL, 8'd1);
        repeat (5) step(st(0, 0, 0, 0, 0, 1, 0, 0));
        step(st(0, 0, 0, 0, 0, 0, 0, 0));
        settle();
        check("refill_wr_n", RIFIFO_, 8'd0);
        step(st(0, 0, 1, 0, 0, 0, 0, 0));
        settle();
        check("dirflip_wr_n", RIFIFO_, 8'd1);
        check("dirflip_rd_n", RDFIFO_, 8'd1);

        // Reset in the middle of a drain at 6 longwords.
        step(st(0, 1, 1, 0, 0, 0, 0, 0));
        repeat (6) step(st(0, 0, 1, 0, 1, 0, 0, 0));
        settle();
        check("pre_rst_rd_n", RDFIFO_, 8'd0);
        step(st(1, 0, 1, 0, 0, 0, 0, 0));
        settle();
        check("midrst_cnt",  FIFO_CNT,   8'd0);
        check("midrst_rd_n", RDFIFO_,    8'd1);
        check("midrst_done", FLUSH_DONE, 8'd0);

        // Random traffic.
        d = 1'b1;
        f = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            if ($urandom_range(0, 19) == 0) d = ~d;
            if ($urandom_range(0, 9) == 0)  f = ~f;
            s = st($urandom_range(0, 199) == 0, $urandom_range(0, 79) == 0, d, f,
                   $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            step(s);
        end

        repeat (3) @(posedge CLK);
        #2;
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have ports: CLK in 1, system clock; RST in 1, synchronous active-high reset.
REQ-002 SHALL have ports: CLR_FIFO in 1, synchronous FIFO clear (start of DMA); DIR in 1, 1 = SCSI->memory, 0 = memory->SCSI; FLUSH in 1, level request to drain a partial FIFO.
REQ-003 SHALL have ports: INCFIFO in 1, fill +1 strobe; DECFIFO in 1, fill -1 strobe; INCNI in 1, write-pointer strobe; INCNO in 1, read-pointer strobe (all single-cycle, active-high, from CPU SM outputs).
REQ-004 SHALL have ports: FIFO_CNT out 4, longwords held (0..8); WRPTR out 3; RDPTR out 3; FIFOFULL out 1; FIFOEMPTY out 1.
REQ-005 SHALL have ports: RDFIFO_ out 1, active-low, CPU SM to read FIFO; RIFIFO_ out 1, active-low, CPU SM to write FIFO; FLUSH_DONE out 1, one-cycle pulse; FIFO_ERR out 1, sticky overflow/underflow.
REQ-006 Clocking and reset SHALL be: one clock CLK; reset RST synchronous, active-high.

Function
REQ-007 All outputs SHALL be registered or decoded only from registers; a strobe at edge N becomes visible after edge N+1.
REQ-008 FIFO_CNT update rules:
  - INCFIFO only: +1
  - DECFIFO only: -1
  - both or neither: hold
REQ-009 INCFIFO-only at FIFO_CNT=8 SHALL hold 8 and set FIFO_ERR; DECFIFO-only at 0 SHALL hold 0 and set FIFO_ERR.
REQ-010 WRPTR SHALL increment mod 8 on INCNI; RDPTR SHALL increment mod 8 on INCNO; 7 wraps to 0; pointers are independent of FIFO_CNT.
REQ-011 FIFOFULL SHALL equal (FIFO_CNT==8); FIFOEMPTY SHALL equal (FIFO_CNT==0).
REQ-012 CLR_FIFO SHALL, next edge, zero FIFO_CNT/WRPTR/RDPTR, clear FIFO_ERR, go to IDLE; it has priority over all strobes in the same cycle.
REQ-013 Request FSM SHALL have states IDLE, DRAIN, FILL, FLUSHING, DONE (3-bit encoding).
REQ-014 IDLE transitions, evaluated on current registered count, first match wins:
  - DIR=1 & FLUSH & CNT>0 -> FLUSHING
  - DIR=1 & CNT>=4 -> DRAIN
  - DIR=1 & FLUSH & CNT=0 -> DONE
  - DIR=0 & CNT<=4 -> FILL
  - otherwise stay in IDLE
REQ-015 DRAIN SHALL drive RDFIFO_=0 and return to IDLE when CNT=0, or when CNT=1 and DECFIFO-only is asserted.
REQ-016 FILL SHALL drive RIFIFO_=0 and return to IDLE when CNT=8, or when CNT=7 and INCFIFO-only is asserted.
REQ-017 FLUSHING SHALL drive RDFIFO_=0 and go to DONE on the same empty condition as DRAIN.
REQ-018 DONE SHALL assert FLUSH_DONE for exactly one cycle, then go to IDLE; it SHALL not re-enter DONE until FLUSH has been seen low.
REQ-019 A DIR change while in DRAIN/FILL/FLUSHING SHALL force IDLE next edge, deasserting both requests.
REQ-020 RDFIFO_ and RIFIFO_ SHALL never be low simultaneously.

Reset
REQ-021 On RST, next edge, outputs SHALL be:
  - FIFO_CNT=0, WRPTR=0, RDPTR=0
  - FIFOEMPTY=1, FIFOFULL=0
  - RDFIFO_=1, RIFIFO_=1
  - FLUSH_DONE=0, FIFO_ERR=0
  - FSM in IDLE
REQ-022 RST mid-DRAIN/FILL SHALL abort without a FLUSH_DONE pulse; RST has priority over CLR_FIFO.

Structure
REQ-023 FSM state encodings, FIFO depth (8) and watermark (4) SHALL live as constants in the shared CPU-SM package.
REQ-024 One sub-module fifo_ptr (3-bit wrap counter with enable and clear) SHALL be instantiated twice, for WRPTR and RDPTR.

Verification
REQ-025 RST, then 5 INCFIFO-only pulses -> FIFO_CNT=5; with DIR=1 the FSM enters DRAIN and RDFIFO_=0; 5 DECFIFO pulses -> CNT=0, RDFIFO_=1.
REQ-026 CNT=8, one INCFIFO-only -> CNT stays 8, FIFO_ERR=1; then CLR_FIFO -> CNT=0, FIFO_ERR=0.
REQ-027 INCFIFO and DECFIFO together at CNT=3 -> CNT stays 3; 9 INCNI pulses -> WRPTR=1.
REQ-028 DIR=1, CNT=2, FLUSH=1 -> FLUSHING, RDFIFO_=0; 2 DECFIFO -> one-cycle FLUSH_DONE; with FLUSH held high, no second pulse.
REQ-029 DIR=0, CNT=0 -> RIFIFO_=0; 8 INCFIFO -> RIFIFO_=1, FIFOFULL=1; DIR toggled mid-FILL -> IDLE next edge.
REQ-030 RST asserted during DRAIN at CNT=6 -> next edge all reset values, no FLUSH_DONE.
